data_bus_mmio: RTL

//  Data-side memory subsystem between the cpu data port and storage. Replaces
//  the fixed data_ram + byte-swap + testLed trio with one parametrised block.

---
 rtl/data_bus_mmio.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_bus_mmio.sv
// Data-side memory subsystem: word RAM with byte enables and selectable lane order,
// plus an MMIO window (RESULT, CYCLE, ERR_CNT) driving a PASS/FAIL LED state machine.
module data_bus_mmio #(
  parameter int          RAM_DEPTH  = 256,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BLINK_HZ   = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  input  logic        MemWrite,
  input  logic [3:0]  be,
  output logic [31:0] dout,
  output logic        led_r,
  output logic        led_g,
  output logic        addr_err
);

  localparam int          AW         = $clog2(RAM_DEPTH);
  localparam int          HALF       = CLK_HZ / (2 * BLINK_HZ);
  localparam int          CW         = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_DEPTH * 4);
  localparam logic [CW-1:0] BLINK_LAST = CW'(HALF - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  // Lane swap is its own inverse, so the same mapping serves stores and loads.
  function automatic logic [31:0] map_lanes(input logic [31:0] x);
    return BIG_ENDIAN ? {x[7:0], x[15:8], x[23:16], x[31:24]} : x;
  endfunction

  logic [31:0]   r_mem [RAM_DEPTH];
  logic [31:0]   r_result;
  logic [31:0]   r_cycle;
  logic [15:0]   r_err_cnt;
  logic [1:0]    r_state;
  logic [CW-1:0] r_blink_cnt;
  logic          r_led_r;
  logic          r_led_g;
  logic          r_addr_err;

  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [AW-1:0] w_idx;
  logic [5:0]    w_word;
  logic [31:0]   w_din_s;
  logic [3:0]    w_be_s;
  logic          w_ram_wr;
  logic          w_result_wr;
  logic          w_unmapped_wr;
  logic [1:0]    w_next_state;
  logic [31:0]   w_rdata;

  assign w_ram_hit     = (daddr < RAM_BYTES);
  assign w_mmio_hit    = !w_ram_hit && (daddr[31:8] == MMIO_BASE[31:8]);
  assign w_idx         = daddr[AW+1:2];
  assign w_word        = daddr[7:2];
  assign w_din_s       = map_lanes(din);
  assign w_be_s        = BIG_ENDIAN ? {be[0], be[1], be[2], be[3]} : be;
  assign w_ram_wr      = MemWrite && w_ram_hit;
  assign w_result_wr   = MemWrite && w_mmio_hit && (w_word == 6'd0);
  assign w_unmapped_wr = MemWrite && !w_ram_hit && !w_mmio_hit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && w_ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be_s[b]) r_mem[w_idx][8*b +: 8] <= w_din_s[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_ram_hit) begin
      w_rdata = map_lanes(r_mem[w_idx]);
    end else if (w_mmio_hit) begin
      case (w_word)
        6'd0:    w_rdata = r_result;
        6'd1:    w_rdata = r_cycle;
        6'd2:    w_rdata = {16'h0, r_err_cnt};
        default: w_rdata = 32'h0;
      endcase
    end
  end

  // FAIL is sticky: once there, RESULT stores no longer move the state.
  always_comb begin
    w_next_state = r_state;
    if (w_result_wr) begin
      case (r_state)
        ST_IDLE: begin
          if (din == 32'd1)      w_next_state = ST_PASS;
          else if (din != 32'd0) w_next_state = ST_FAIL;
        end
        ST_PASS: begin
          if (din == 32'd0)      w_next_state = ST_IDLE;
          else if (din != 32'd1) w_next_state = ST_FAIL;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_result    <= 32'h0;
      r_cycle     <= 32'h0;
      r_err_cnt   <= 16'h0;
      r_state     <= ST_IDLE;
      r_blink_cnt <= '0;
      r_led_r     <= 1'b0;
      r_led_g     <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_cycle    <= r_cycle + 32'd1;
      r_addr_err <= w_unmapped_wr;
      if (w_result_wr) r_result <= din;
      if (w_unmapped_wr && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      r_state <= w_next_state;
      r_led_g <= (w_next_state == ST_PASS);
      if (w_next_state == ST_FAIL) begin
        if (r_state != ST_FAIL) begin
          r_led_r     <= 1'b1;
          r_blink_cnt <= '0;
        end else if (r_blink_cnt == BLINK_LAST) begin
          r_led_r     <= ~r_led_r;
          r_blink_cnt <= '0;
        end else begin
          r_blink_cnt <= r_blink_cnt + CW'(1);
        end
      end else begin
        r_led_r     <= 1'b0;
        r_blink_cnt <= '0;
      end
    end
  end

  assign dout     = w_rdata;
  assign led_r    = r_led_r;
  assign led_g    = r_led_g;
  assign addr_err = r_addr_err;

endmodule
